// File: rtl/lsb_queue.sv
// In-order load/store queue for the Tomasulo core.
// Entries snoop the ALU CDB and the queue's own load-result bus for operands.
// One memory access at a time is issued from the head. Stores, and by default
// every load, wait for ROB commit. Committed entries survive a rollback.
// Optional feature macro: LSB_IO_GUARD_EN. When defined, loads below IO_BASE
// issue speculatively and only I/O loads wait for commit.
module lsb_queue #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ROB_W   = 4,
    parameter logic [31:0] IO_BASE = 32'h30000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    output logic             lsb_full,
    // dispatch
    input  logic             disp_valid,
    input  logic [3:0]       disp_op,
    input  logic [ROB_W-1:0] disp_tag,
    input  logic [ROB_W-1:0] disp_qi,
    input  logic [ROB_W-1:0] disp_qj,
    input  logic [31:0]      disp_vi,
    input  logic [31:0]      disp_vj,
    input  logic [31:0]      disp_imm,
    // ALU CDB
    input  logic             alu_valid,
    input  logic [ROB_W-1:0] alu_tag,
    input  logic [31:0]      alu_data,
    // ROB
    input  logic             commit_valid,
    input  logic [ROB_W-1:0] commit_tag,
    input  logic             rollback,
    // memory controller
    output logic             mem_valid,
    output logic [3:0]       mem_op,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_done,
    input  logic [31:0]      mem_rdata,
    // load result CDB
    output logic             res_valid,
    output logic [ROB_W-1:0] res_tag,
    output logic [31:0]      res_data
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic             valid;
        logic             cmt;
        logic [3:0]       op;
        logic [ROB_W-1:0] tag;
        logic [ROB_W-1:0] qi;
        logic [ROB_W-1:0] qj;
        logic [31:0]      vi;
        logic [31:0]      vj;
        logic [31:0]      imm;
    } entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDrain
    } state_e;

    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    state_e          state_q, state_d;
    logic            mem_valid_q, mem_valid_d;
    logic [3:0]      mem_op_q, mem_op_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic [ROB_W-1:0] inf_tag_q, inf_tag_d;
    logic            res_valid_q, res_valid_d;
    logic [ROB_W-1:0] res_tag_q, res_tag_d;
    logic [31:0]     res_data_q, res_data_d;

    entry_t          head_ent;
    entry_t          new_ent;
    logic [31:0]     head_addr;
    logic            head_ready;
    logic            head_io;
    logic            ld_spec_ok;
    logic            issue;
    logic [CntW-1:0] ncmt;
    logic [31:0]     ext_data;

    // Capture an operand from either broadcast bus; ALU has priority.
    function automatic entry_t snoop(input entry_t e,
                                     input logic av, input logic [ROB_W-1:0] at,
                                     input logic [31:0] ad,
                                     input logic rv, input logic [ROB_W-1:0] rt,
                                     input logic [31:0] rd);
        entry_t s;
        s = e;
        if (s.qi != '0) begin
            if (av && s.qi == at) begin
                s.vi = ad;
                s.qi = '0;
            end else if (rv && s.qi == rt) begin
                s.vi = rd;
                s.qi = '0;
            end
        end
        if (s.qj != '0) begin
            if (av && s.qj == at) begin
                s.vj = ad;
                s.qj = '0;
            end else if (rv && s.qj == rt) begin
                s.vj = rd;
                s.qj = '0;
            end
        end
        return s;
    endfunction

    // Decide whether the head entry may be sent to memory this cycle.
    always_comb begin
        head_ent   = ent_q[head_q];
        head_addr  = head_ent.vi + head_ent.imm;
        head_io    = (head_addr >= IO_BASE);
        head_ready = head_ent.valid && (head_ent.qi == '0) &&
                     (!head_ent.op[3] || (head_ent.qj == '0));
`ifdef LSB_IO_GUARD_EN
        ld_spec_ok = !head_io;
`else
        // Address class is irrelevant: no load ever issues before commit.
        ld_spec_ok = 1'b0 & head_io;
`endif
        issue = (state_q == StIdle) && !rollback && head_ready &&
                (head_ent.cmt || (!head_ent.op[3] && ld_spec_ok));
    end

    // Incoming dispatch entry, with same-cycle CDB bypass applied.
    always_comb begin
        new_ent       = '0;
        new_ent.valid = 1'b1;
        new_ent.cmt   = 1'b0;
        new_ent.op    = disp_op;
        new_ent.tag   = disp_tag;
        new_ent.qi    = disp_qi;
        new_ent.qj    = disp_qj;
        new_ent.vi    = disp_vi;
        new_ent.vj    = disp_vj;
        new_ent.imm   = disp_imm;
        new_ent = snoop(new_ent, alu_valid, alu_tag, alu_data,
                        res_valid_q, res_tag_q, res_data_q);
    end

    // Queue next state: snoop, commit marking, rollback flush, pop and push.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ncmt    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid) begin
                ent_d[i] = snoop(ent_q[i], alu_valid, alu_tag, alu_data,
                                 res_valid_q, res_tag_q, res_data_q);
                if (commit_valid && !rollback && ent_q[i].tag == commit_tag) begin
                    ent_d[i].cmt = 1'b1;
                end
            end
            ncmt = ncmt + CntW'(ent_q[i].valid & ent_q[i].cmt);
        end
        if (rollback) begin
            // Committed entries are contiguous from head, so they stay put.
            for (int i = 0; i < DEPTH; i++) begin
                if (!ent_q[i].cmt) begin
                    ent_d[i] = '0;
                end
            end
            tail_d  = head_q + ncmt[PtrW-1:0];
            count_d = ncmt;
        end else begin
            if (issue) begin
                ent_d[head_q] = '0;
                head_d        = head_q + 1'b1;
            end
            // Push after pop so a full-queue pop+push reuses the freed slot.
            if (disp_valid) begin
                ent_d[tail_q] = new_ent;
                tail_d        = tail_q + 1'b1;
            end
            count_d = count_q + CntW'(disp_valid) - CntW'(issue);
        end
    end

    // Sign or zero extension of the raw load data for the in-flight op.
    always_comb begin
        ext_data = mem_rdata;
        unique case (mem_op_q[1:0])
            2'd0:    ext_data = {{24{~mem_op_q[2] & mem_rdata[7]}}, mem_rdata[7:0]};
            2'd1:    ext_data = {{16{~mem_op_q[2] & mem_rdata[15]}}, mem_rdata[15:0]};
            default: ext_data = mem_rdata;
        endcase
    end

    // Memory FSM next state and registered memory / result outputs.
    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_op_d    = mem_op_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        inf_tag_d   = inf_tag_q;
        res_valid_d = 1'b0;
        res_tag_d   = res_tag_q;
        res_data_d  = res_data_q;
        unique case (state_q)
            StIdle: begin
                if (issue) begin
                    mem_valid_d = 1'b1;
                    mem_op_d    = head_ent.op;
                    mem_addr_d  = head_addr;
                    mem_wdata_d = head_ent.vj;
                    inf_tag_d   = head_ent.tag;
                    state_d     = StBusy;
                end
            end
            StBusy: begin
                if (mem_done) begin
                    mem_valid_d = 1'b0;
                    state_d     = StIdle;
                    if (!mem_op_q[3] && !rollback) begin
                        res_valid_d = 1'b1;
                        res_tag_d   = inf_tag_q;
                        res_data_d  = ext_data;
                    end
                end else if (rollback && !mem_op_q[3]) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Speculative load result is discarded.
                if (mem_done) begin
                    mem_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Queue storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // FSM state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mem_valid_q <= 1'b0;
            mem_op_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            inf_tag_q   <= '0;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_data_q  <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_op_q    <= mem_op_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            inf_tag_q   <= inf_tag_d;
            res_valid_q <= res_valid_d;
            res_tag_q   <= res_tag_d;
            res_data_q  <= res_data_d;
        end
    end

    assign lsb_full  = (count_q == CntW'(DEPTH));
    assign mem_valid = mem_valid_q;
    assign mem_op    = mem_op_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign res_valid = res_valid_q;
    assign res_tag   = res_tag_q;
    assign res_data  = res_data_q;

endmodule
